// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types and the MCU slot order.
// DCT_MCU_SCHED_444_EN selects the 4:4:4 order (Y, Cb, Cr); otherwise 4:2:0 (Y x4, Cb, Cr).
package jpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_id_t;

    localparam int unsigned ROWS_PER_BLK = 8;
    localparam int unsigned ROW_W        = $clog2(ROWS_PER_BLK);

`ifdef DCT_MCU_SCHED_444_EN
    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned SLOT_W    = 2;
    localparam comp_id_t    MCU_ORDER [NUM_SLOTS] = '{COMP_Y, COMP_CB, COMP_CR};
`else
    localparam int unsigned NUM_SLOTS = 6;
    localparam int unsigned SLOT_W    = 3;
    localparam comp_id_t    MCU_ORDER [NUM_SLOTS] =
        '{COMP_Y, COMP_Y, COMP_Y, COMP_Y, COMP_CB, COMP_CR};
`endif

    // Component served by a slot; unused pointer codes fall back to Y.
    function automatic comp_id_t slot_comp(input logic [SLOT_W-1:0] slot);
        comp_id_t c;
        c = COMP_Y;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot == SLOT_W'(i)) begin
                c = MCU_ORDER[i];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dct_row_reg.sv
// One-deep valid/ready output register for a DCT row beat plus its sop/eop/comp tags.
module dct_row_reg
    import jpeg_pkg::*;
#(
    parameter int unsigned W_I = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [8*W_I-1:0] in_data_i,
    input  logic             in_sop_i,
    input  logic             in_eop_i,
    input  comp_id_t         in_comp_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [8*W_I-1:0] out_data_o,
    output logic             out_sop_o,
    output logic             out_eop_o,
    output logic [1:0]       out_comp_o
);

    logic             valid_q, valid_d;
    logic [8*W_I-1:0] data_q, data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    comp_id_t         comp_q, comp_d;
    logic             load;

    // Accept whenever the slot is empty or is being drained this cycle.
    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    // Next-state: load a new beat, drain, or hold (payload frozen while stalled).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        comp_d  = comp_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            sop_d   = in_sop_i;
            eop_d   = in_eop_i;
            comp_d  = in_comp_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register state; reset empties the slot and clears the payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            comp_q  <= COMP_Y;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            comp_q  <= comp_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sop_o   = sop_q;
    assign out_eop_o   = eop_q;
    assign out_comp_o  = comp_q;

endmodule

// File: rtl/dct_mcu_sched.sv
// Shares one DCT core among the Y/Cb/Cr row streams, eight rows per block in MCU slot order.
// Define DCT_MCU_SCHED_444_EN for the 4:4:4 slot order; default is 4:2:0.
module dct_mcu_sched
    import jpeg_pkg::*;
#(
    parameter int unsigned W_I   = 8,
    parameter int unsigned W_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sched_en,
    input  logic             mcu_restart,
    input  logic             y_valid,
    input  logic             cb_valid,
    input  logic             cr_valid,
    output logic             y_ready,
    output logic             cb_ready,
    output logic             cr_ready,
    input  logic [8*W_I-1:0] y_data,
    input  logic [8*W_I-1:0] cb_data,
    input  logic [8*W_I-1:0] cr_data,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic [8*W_I-1:0] dct_data,
    output logic             dct_sop,
    output logic             dct_eop,
    output logic [1:0]       dct_comp,
    output logic             busy,
    output logic             mcu_done,
    output logic [W_CNT-1:0] mcu_cnt
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              done_q, done_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;

    comp_id_t          sel_comp;
    logic              sel_valid;
    logic [8*W_I-1:0]  sel_data;
    logic              xfer;
    logic              reg_ready;
    logic              accept;
    logic              last_row;
    logic              last_slot;

    assign sel_comp  = slot_comp(slot_q);
    assign xfer      = (state_q == StXfer);
    assign last_row  = (row_q == ROW_W'(ROWS_PER_BLK - 1));
    assign last_slot = (slot_q == SLOT_W'(NUM_SLOTS - 1));
    assign accept    = xfer && sel_valid && reg_ready;

    // Source mux: only the component owning the current slot is visible.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        case (sel_comp)
            COMP_Y:  begin sel_valid = y_valid;  sel_data = y_data;  end
            COMP_CB: begin sel_valid = cb_valid; sel_data = cb_data; end
            COMP_CR: begin sel_valid = cr_valid; sel_data = cr_data; end
            default: ;
        endcase
    end

    // Readies are zero in IDLE and for every source not owning the slot.
    assign y_ready  = xfer && (sel_comp == COMP_Y)  && reg_ready;
    assign cb_ready = xfer && (sel_comp == COMP_CB) && reg_ready;
    assign cr_ready = xfer && (sel_comp == COMP_CR) && reg_ready;

    // Next-state: sched_en only matters on entry from IDLE and on the eighth row of a block.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        row_d   = row_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mcu_restart) begin
                    slot_d = '0;
                end
                if (sched_en) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    row_d = row_q + ROW_W'(1);
                    if (last_row) begin
                        if (last_slot) begin
                            slot_d = '0;
                            done_d = 1'b1;
                            cnt_d  = cnt_q + W_CNT'(1);
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                        if (!sched_en) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointers and MCU counter; mcu_done lines up with the last row's dct_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            slot_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    dct_row_reg #(
        .W_I (W_I)
    ) u_row_reg (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (xfer && sel_valid),
        .in_ready_o  (reg_ready),
        .in_data_i   (sel_data),
        .in_sop_i    (row_q == '0),
        .in_eop_i    (last_row),
        .in_comp_i   (sel_comp),
        .out_valid_o (dct_valid),
        .out_ready_i (dct_ready),
        .out_data_o  (dct_data),
        .out_sop_o   (dct_sop),
        .out_eop_o   (dct_eop),
        .out_comp_o  (dct_comp)
    );

    assign busy     = xfer;
    assign mcu_done = done_q;
    assign mcu_cnt  = cnt_q;

endmodule

// File: tb/tb_dct_mcu_sched.sv
// Directed bench for dct_mcu_sched: MCU order, tags, backpressure, disable/restart, stall,
// counter wrap (second instance with W_CNT = 2) and asynchronous reset.
module tb_dct_mcu_sched;

`ifdef DCT_MCU_SCHED_444_EN
    localparam int NSL = 3, CB_SLOT = 1, CR_SLOT = 2;
`else
    localparam int NSL = 6, CB_SLOT = 4, CR_SLOT = 5;
`endif
    localparam int MCU_BEATS = NSL * 8;

    logic        clk, rst_n, sched_en, mcu_restart;
    logic        y_valid, cb_valid, cr_valid;
    logic        y_ready, cb_ready, cr_ready;
    logic [63:0] y_data, cb_data, cr_data;
    logic        dct_valid, dct_ready, dct_sop, dct_eop, busy, mcu_done;
    logic [63:0] dct_data;
    logic [1:0]  dct_comp;
    logic [15:0] mcu_cnt;

    logic        w2_y_ready, w2_cb_ready, w2_cr_ready, w2_valid, w2_sop, w2_eop;
    logic        w2_busy, w2_done;
    logic [63:0] w2_data;
    logic [1:0]  w2_comp;
    logic [1:0]  w2_cnt;

    dct_mcu_sched #(.W_I(8), .W_CNT(16)) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .mcu_restart(mcu_restart),
        .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
        .y_ready(y_ready), .cb_ready(cb_ready), .cr_ready(cr_ready),
        .y_data(y_data), .cb_data(cb_data), .cr_data(cr_data),
        .dct_valid(dct_valid), .dct_ready(dct_ready), .dct_data(dct_data),
        .dct_sop(dct_sop), .dct_eop(dct_eop), .dct_comp(dct_comp),
        .busy(busy), .mcu_done(mcu_done), .mcu_cnt(mcu_cnt)
    );

    dct_mcu_sched #(.W_I(8), .W_CNT(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .mcu_restart(mcu_restart),
        .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
        .y_ready(w2_y_ready), .cb_ready(w2_cb_ready), .cr_ready(w2_cr_ready),
        .y_data(y_data), .cb_data(cb_data), .cr_data(cr_data),
        .dct_valid(w2_valid), .dct_ready(dct_ready), .dct_data(w2_data),
        .dct_sop(w2_sop), .dct_eop(w2_eop), .dct_comp(w2_comp),
        .busy(w2_busy), .mcu_done(w2_done), .mcu_cnt(w2_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sources: each emits a tagged running sequence number, advanced on its own accept.
    logic [31:0] y_seq, cb_seq, cr_seq;
    assign y_data  = {8'hA0, 24'h0, y_seq};
    assign cb_data = {8'hA1, 24'h0, cb_seq};
    assign cr_data = {8'hA2, 24'h0, cr_seq};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_seq  <= '0;
            cb_seq <= '0;
            cr_seq <= '0;
        end else begin
            if (y_valid && y_ready)   y_seq  <= y_seq + 1;
            if (cb_valid && cb_ready) cb_seq <= cb_seq + 1;
            if (cr_valid && cr_ready) cr_seq <= cr_seq + 1;
        end
    end

    function automatic int comp_of(input int slot);
        if (slot < CB_SLOT) return 0;
        if (slot == CB_SLOT) return 1;
        return 2;
    endfunction

    // Reference model of the presented beat, stepped at the falling edge.
    int          m_slot = 0, m_row = 0, beat_cnt = 0;
    int          restart_req = 0, restart_ack = 0;
    int          exp_seq [3];
    logic [15:0] exp_cnt = '0;
    logic        prev_stall = 1'b0;
    logic [63:0] held_data;
    logic [3:0]  held_tags;
    logic        newb, exp_done;
    int          c;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_slot = 0; m_row = 0; exp_cnt = '0; prev_stall = 1'b0;
            exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0;
            restart_ack = restart_req;
        end else begin
            if (restart_ack != restart_req) begin
                m_slot = 0; m_row = 0; restart_ack = restart_req;
            end
            newb     = dct_valid && !prev_stall;
            exp_done = newb && (m_row == 7) && (m_slot == NSL - 1);
            if (exp_done) exp_cnt = exp_cnt + 1;
            check("mcu_done", {63'h0, mcu_done}, {63'h0, exp_done});
            check("mcu_cnt", {48'h0, mcu_cnt}, {48'h0, exp_cnt});
            check("mcu_cnt_w2", {62'h0, w2_cnt}, {62'h0, exp_cnt[1:0]});
            if (prev_stall) begin
                check("hold_data", dct_data, held_data);
                check("hold_tags", {60'h0, dct_sop, dct_eop, dct_comp}, {60'h0, held_tags});
            end
            if (dct_valid && dct_ready) begin
                c = comp_of(m_slot);
                check("comp", {62'h0, dct_comp}, 64'(c));
                check("sop", {63'h0, dct_sop}, {63'h0, m_row == 0});
                check("eop", {63'h0, dct_eop}, {63'h0, m_row == 7});
                check("data", dct_data, {8'hA0 + 8'(c), 24'h0, 32'(exp_seq[c])});
                exp_seq[c]++;
                beat_cnt++;
                if (m_row == 7) begin
                    m_row  = 0;
                    m_slot = (m_slot == NSL - 1) ? 0 : m_slot + 1;
                end else begin
                    m_row++;
                end
            end
            prev_stall = dct_valid && !dct_ready;
            held_data  = dct_data;
            held_tags  = {dct_sop, dct_eop, dct_comp};
        end
    end

    logic bp = 1'b0;

    // Step until n more beats are handed over; returns cycles spent.
    task automatic run_beats(input int n, input string tag, output int cycles);
        int target;
        target = beat_cnt + n;
        cycles = 0;
        while (beat_cnt < target && cycles < n * 4 + 50) begin
            @(posedge clk); #1;
            if (bp) dct_ready = ~dct_ready;
            cycles++;
        end
        if (beat_cnt < target) check({tag, "_timeout"}, 64'(beat_cnt), 64'(target));
    endtask

    task automatic wait_model(input int slot, input int row, input string tag);
        int n;
        n = 0;
        while (!(m_slot == slot && m_row == row) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check({tag, "_timeout"}, 64'(n), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'h0, dct_valid}, 64'd0);
        check({tag, "_data"}, dct_data, 64'd0);
        check({tag, "_tags"}, {60'h0, dct_sop, dct_eop, dct_comp}, 64'd0);
        check({tag, "_busy"}, {63'h0, busy}, 64'd0);
        check({tag, "_done"}, {63'h0, mcu_done}, 64'd0);
        check({tag, "_cnt"}, {48'h0, mcu_cnt}, 64'd0);
        check({tag, "_readies"}, {61'h0, y_ready, cb_ready, cr_ready}, 64'd0);
    endtask

    initial begin
        int cyc, b0;
        rst_n = 1'b0; sched_en = 1'b0; mcu_restart = 1'b0;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0; dct_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Full MCU at full throughput: no bubble between beats.
        rst_n = 1'b1;
        y_valid = 1'b1; cb_valid = 1'b1; cr_valid = 1'b1; dct_ready = 1'b1; sched_en = 1'b1;
        run_beats(1, "first", cyc);
        run_beats(MCU_BEATS - 1, "full", cyc);
        check("full_cycles", 64'(cyc), 64'(MCU_BEATS - 1));
        check("mcu_cnt_1", {48'h0, mcu_cnt}, 64'd1);

        // Backpressure 1010..., plus a restart pulse in XFER which must be ignored.
        mcu_restart = 1'b1;
        @(posedge clk); #1;
        mcu_restart = 1'b0;
        bp = 1'b1;
        run_beats(MCU_BEATS, "bp", cyc);
        bp = 1'b0;
        dct_ready = 1'b1;
        check("bp_cycles_ok", {63'h0, cyc >= 2 * MCU_BEATS - 6 && cyc <= 2 * MCU_BEATS + 4}, 64'd1);

        // Cb stalls while Cr is valid: Cr must not be served out of order.
        wait_model(0, 0, "stall_sync");
        cb_valid = 1'b0;
        wait_model(CB_SLOT, 0, "stall_reach");
        repeat (3) @(posedge clk);
        #1;
        b0 = beat_cnt;
        check("stall_valid", {63'h0, dct_valid}, 64'd0);
        check("stall_readies", {61'h0, y_ready, cb_ready, cr_ready}, 64'b010);
        repeat (2) @(posedge clk);
        #1;
        check("stall_no_beat", 64'(beat_cnt), 64'(b0));
        cb_valid = 1'b1;

        // Disable mid-Cb: block completes, resume starts with Cr.
        wait_model(CB_SLOT, 3, "dis_reach");
        sched_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        b0 = beat_cnt;
        check("idle_busy", {63'h0, busy}, 64'd0);
        check("idle_valid", {63'h0, dct_valid}, 64'd0);
        check("idle_readies", {61'h0, y_ready, cb_ready, cr_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_beat", 64'(beat_cnt), 64'(b0));
        sched_en = 1'b1;
        run_beats(8, "resume_cr", cyc);

        // Disable mid-Cb again, restart in IDLE: resume starts with Y.
        wait_model(CB_SLOT, 3, "rst_reach");
        sched_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        mcu_restart = 1'b1;
        restart_req++;
        @(posedge clk); #1;
        mcu_restart = 1'b0;
        sched_en = 1'b1;
        run_beats(3 * MCU_BEATS, "tail", cyc);

        // Asynchronous reset in the middle of a block.
        wait_model(0, 3, "arst_reach");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_beats(MCU_BEATS + 1, "post_rst", cyc);
        check("post_rst_cnt", {48'h0, mcu_cnt}, 64'd1);

        sched_en = 1'b0;
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
